// File: rtl/header_frame_receiver_if.sv
// rtl/header_frame_receiver_if.sv - UART byte handshake and header hand-off bundle
interface header_frame_receiver_if #(
    parameter int HEADER_BYTES = 80
);
    logic [7:0]                  rx_byte;
    logic                        rx_ready;
    logic                        rdy_clr;
    logic [8*HEADER_BYTES-1:0]   header;
    logic                        header_valid;
    logic                        header_ack;

    modport master (
        output rx_byte, rx_ready, header_ack,
        input  rdy_clr, header, header_valid
    );

    modport slave (
        input  rx_byte, rx_ready, header_ack,
        output rdy_clr, header, header_valid
    );
endinterface

// File: rtl/header_frame_receiver.sv
// rtl/header_frame_receiver.sv - assembles UART bytes into a fixed-size block header frame
module header_frame_receiver #(
    parameter int HEADER_BYTES   = 80,
    parameter int TIMEOUT_CYCLES = 50000
) (
    input  logic                    clock_i,
    input  logic                    reset_ni,
    header_frame_receiver_if.slave  rx_if,
    output logic [6:0]              byte_count_o,
    output logic                    frame_error_o,
    output logic                    overrun_o
);
    localparam int HW = 8 * HEADER_BYTES;
    localparam int TW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [6:0]    LAST_BYTE = 7'(HEADER_BYTES - 1);
    localparam logic [TW-1:0] TMO_LAST  = TW'(TIMEOUT_CYCLES - 1);

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_RECEIVE = 2'd1,
        S_HOLD    = 2'd2
    } state_e;

    state_e          state_q, state_d;
    logic [HW-1:0]   header_q, header_d;
    logic [6:0]      count_q, count_d;
    logic [TW-1:0]   tmo_q, tmo_d;
    logic            rdy_clr_q, rdy_clr_d;
    logic            blank_q, blank_d;
    logic            ferr_q, ferr_d;
    logic            overrun_q, overrun_d;
    logic            accept;

    // The UART may keep rx_ready high for one cycle after the clear pulse,
    // so the cycle following rdy_clr is also blanked.
    assign accept = rx_if.rx_ready && !rdy_clr_q && !blank_q;

    always_ff @(posedge clock_i or negedge reset_ni) begin
        if (!reset_ni) begin
            state_q   <= S_IDLE;
            header_q  <= '0;
            count_q   <= '0;
            tmo_q     <= '0;
            rdy_clr_q <= 1'b0;
            blank_q   <= 1'b0;
            ferr_q    <= 1'b0;
            overrun_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            header_q  <= header_d;
            count_q   <= count_d;
            tmo_q     <= tmo_d;
            rdy_clr_q <= rdy_clr_d;
            blank_q   <= blank_d;
            ferr_q    <= ferr_d;
            overrun_q <= overrun_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        header_d  = header_q;
        count_d   = count_q;
        tmo_d     = '0;
        rdy_clr_d = accept;
        blank_d   = rdy_clr_q;
        ferr_d    = 1'b0;
        overrun_d = overrun_q;
        case (state_q)
            S_IDLE, S_RECEIVE: begin
                if (accept) begin
                    header_d = {header_q[HW-9:0], rx_if.rx_byte};
                    if (count_q == LAST_BYTE) begin
                        count_d = '0;
                        state_d = S_HOLD;
                    end else begin
                        count_d = count_q + 7'd1;
                        state_d = S_RECEIVE;
                    end
                end else if (state_q == S_RECEIVE) begin
                    if (tmo_q == TMO_LAST) begin
                        state_d = S_IDLE;
                        count_d = '0;
                        ferr_d  = 1'b1;
                    end else begin
                        tmo_d = tmo_q + 1'b1;
                    end
                end
            end
            S_HOLD: begin
                // A drained byte in the ack cycle keeps overrun set.
                if (rx_if.header_ack) begin
                    state_d   = S_IDLE;
                    overrun_d = 1'b0;
                end
                if (accept) begin
                    overrun_d = 1'b1;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        rx_if.rdy_clr      = rdy_clr_q;
        rx_if.header       = header_q;
        rx_if.header_valid = (state_q == S_HOLD);
        byte_count_o       = count_q;
        frame_error_o      = ferr_q;
        overrun_o          = overrun_q;
    end
endmodule

// File: tb/tb_header_frame_receiver.sv
// tb/tb_header_frame_receiver.sv - directed bench with a per-cycle frame model
module tb_header_frame_receiver;
    localparam int HB = 80;
    localparam int T  = 200;
    localparam int HW = 8 * HB;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [6:0] byte_count;
    logic       frame_error;
    logic       overrun;

    header_frame_receiver_if #(.HEADER_BYTES(HB)) bus ();

    header_frame_receiver #(
        .HEADER_BYTES  (HB),
        .TIMEOUT_CYCLES(T)
    ) dut (
        .clock_i      (clk),
        .reset_ni     (rst_n),
        .rx_if        (bus),
        .byte_count_o (byte_count),
        .frame_error_o(frame_error),
        .overrun_o    (overrun)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    task automatic chk(input string nm, input logic [HW-1:0] act, input logic [HW-1:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // Model: the frame in progress is a queue of bytes; a completed frame is held until acked.
    logic [7:0]    frm[$];
    logic [HW-1:0] m_hdr;
    bit            m_valid, m_ovr, m_ferr, m_rdy;
    int            blk, idle;
    int            rdy_pulses = 0;
    int            ferr_pulses = 0;

    task automatic model_reset();
        frm.delete();
        m_hdr   = '0;
        m_valid = 0;
        m_ovr   = 0;
        m_ferr  = 0;
        m_rdy   = 0;
        blk     = 0;
        idle    = 0;
    endtask

    task automatic model_step();
        bit acc;
        if (!rst_n) begin
            model_reset();
            return;
        end
        acc    = bus.rx_ready && (blk == 0);
        m_rdy  = acc;
        m_ferr = 0;
        if (acc) blk = 2;
        else if (blk > 0) blk--;
        if (m_valid) begin
            if (acc) m_ovr = 1;
            else if (bus.header_ack) m_ovr = 0;
            if (bus.header_ack) m_valid = 0;
        end else if (acc) begin
            frm.push_back(bus.rx_byte);
            idle = 0;
            if (frm.size() == HB) begin
                m_hdr = '0;
                foreach (frm[i]) m_hdr = {m_hdr[HW-9:0], frm[i]};
                m_valid = 1;
                frm.delete();
            end
        end else if (frm.size() > 0) begin
            if (idle == T - 1) begin
                frm.delete();
                m_ferr = 1;
                idle   = 0;
            end else begin
                idle++;
            end
        end
    endtask

    initial begin
        model_reset();
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                model_reset();
                chk("rst_header", bus.header, '0);
            end
            chk("byte_count", HW'(byte_count), HW'(frm.size()));
            chk("header_valid", HW'(bus.header_valid), HW'(m_valid));
            chk("rdy_clr", HW'(bus.rdy_clr), HW'(m_rdy));
            chk("frame_error", HW'(frame_error), HW'(m_ferr));
            chk("overrun", HW'(overrun), HW'(m_ovr));
            if (m_valid) chk("header", bus.header, m_hdr);
            if (bus.rdy_clr) rdy_pulses++;
            if (frame_error) ferr_pulses++;
            model_step();
        end
    end

    task automatic send(input logic [7:0] b, input int hold, input int gap);
        @(posedge clk); #1;
        bus.rx_byte  = b;
        bus.rx_ready = 1'b1;
        repeat (hold) @(posedge clk);
        #1;
        bus.rx_ready = 1'b0;
        repeat (gap) @(posedge clk);
    endtask

    task automatic ack();
        @(posedge clk); #1;
        bus.header_ack = 1'b1;
        @(posedge clk); #1;
        bus.header_ack = 1'b0;
    endtask

    logic [HW-1:0] exp_hdr;
    int r0, f0;

    initial begin
        bus.rx_byte    = '0;
        bus.rx_ready   = 1'b0;
        bus.header_ack = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("reset_count", HW'(byte_count), '0);
        chk("reset_valid", HW'(bus.header_valid), '0);
        chk("reset_overrun", HW'(overrun), '0);
        rst_n = 1'b1;

        // Frame 0x00..0x4F, 20-cycle gaps
        r0 = rdy_pulses;
        for (int i = 0; i < HB; i++) send(8'(i), 1, (i == HB - 1) ? 0 : 20);
        chk("hv_latency", HW'(bus.header_valid), HW'(1'b1));
        chk("hdr_first", HW'(bus.header[639:632]), HW'(8'h00));
        chk("hdr_last", HW'(bus.header[7:0]), HW'(8'h4F));
        repeat (2) @(posedge clk);
        #1;
        chk("rdy_pulses_80", HW'(rdy_pulses - r0), HW'(80));
        ack();
        chk("ack_valid", HW'(bus.header_valid), '0);

        // rx_ready held 3 cycles per byte
        for (int i = 0; i < HB; i++) begin
            send(8'hA0 ^ 8'(i), 3, 2);
            if (i < HB - 1) chk("hold3_count", HW'(byte_count), HW'(i + 1));
        end
        chk("hold3_valid", HW'(bus.header_valid), HW'(1'b1));
        chk("hold3_first", HW'(bus.header[639:632]), HW'(8'hA0));
        ack();

        // Ack outside HOLD is ignored
        ack();
        chk("idle_ack_valid", HW'(bus.header_valid), '0);

        // Timeout after 10 bytes, then a full good frame
        f0 = ferr_pulses;
        for (int i = 0; i < 10; i++) send(8'hEE, 1, 2);
        repeat (T + 5) @(posedge clk);
        #1;
        chk("timeout_pulses", HW'(ferr_pulses - f0), HW'(1));
        chk("timeout_count", HW'(byte_count), '0);
        exp_hdr = '0;
        for (int i = 0; i < HB; i++) begin
            send(8'h10 + 8'(i), 1, 2);
            exp_hdr = {exp_hdr[HW-9:0], 8'h10 + 8'(i)};
        end
        chk("post_to_valid", HW'(bus.header_valid), HW'(1'b1));
        chk("post_to_header", bus.header, exp_hdr);

        // Bytes arriving in HOLD are drained and flagged
        r0 = rdy_pulses;
        send(8'h77, 1, 2);
        send(8'h88, 1, 2);
        chk("hold_header", bus.header, exp_hdr);
        chk("hold_overrun", HW'(overrun), HW'(1'b1));
        chk("hold_rdy_pulses", HW'(rdy_pulses - r0), HW'(2));
        @(posedge clk); #1;
        bus.rx_byte    = 8'h99;
        bus.rx_ready   = 1'b1;
        bus.header_ack = 1'b1;
        @(posedge clk); #1;
        bus.rx_ready   = 1'b0;
        bus.header_ack = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("drop_ack_overrun", HW'(overrun), HW'(1'b1));
        chk("drop_ack_valid", HW'(bus.header_valid), '0);
        chk("drop_ack_count", HW'(byte_count), '0);

        // Accept in the expiry cycle wins over the timeout
        f0 = ferr_pulses;
        send(8'h31, 1, T - 2);
        send(8'h32, 1, 2);
        chk("race_count", HW'(byte_count), HW'(2));
        chk("race_no_ferr", HW'(ferr_pulses - f0), '0);

        // Reset after 40 bytes, then a fresh frame
        for (int i = 0; i < 38; i++) send(8'h40, 1, 2);
        chk("pre_reset_count", HW'(byte_count), HW'(40));
        @(posedge clk); #1;
        rst_n = 1'b0;
        @(posedge clk); #1;
        chk("mid_rst_count", HW'(byte_count), '0);
        chk("mid_rst_header", bus.header, '0);
        chk("mid_rst_overrun", HW'(overrun), '0);
        chk("mid_rst_rdy_clr", HW'(bus.rdy_clr), '0);
        rst_n = 1'b1;
        exp_hdr = '0;
        for (int i = 0; i < HB; i++) begin
            send(8'hC0 + 8'(i), 1, 2);
            exp_hdr = {exp_hdr[HW-9:0], 8'hC0 + 8'(i)};
        end
        chk("fresh_valid", HW'(bus.header_valid), HW'(1'b1));
        chk("fresh_header", bus.header, exp_hdr);
        ack();
        chk("fresh_ack_valid", HW'(bus.header_valid), '0);

        repeat (5) @(posedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/header_frame_receiver.md
HEADER_FRAME_RECEIVER -- requirements
Module: header_frame_receiver

Interface
REQ-001 Parameter HEADER_BYTES, default 80, bytes per block-header frame; frame width is 8*HEADER_BYTES bits (640).
REQ-002 Parameter TIMEOUT_CYCLES, default 50000, idle clock cycles within a partial frame before it is discarded.
REQ-003 clock  input  1  single clock; all state updates on its rising edge.
REQ-004 reset  input  1  asynchronous, active-low; all state cleared while low.
REQ-005 rx_byte  input  8  byte from the UART receiver, valid while rx_ready=1.
REQ-006 rx_ready  input  1  UART receiver byte-available flag, level, held until cleared.
REQ-007 rdy_clr  output  1  one-cycle clear pulse to the UART receiver.
REQ-008 header  output  640  assembled header, first received byte in [639:632].
REQ-009 header_valid  output  1  complete frame held on header.
REQ-010 header_ack  input  1  consumer (miner core) has taken the header.
REQ-011 byte_count  output  7  bytes accepted in the current frame, 0..HEADER_BYTES-1.
REQ-012 frame_error  output  1  one-cycle pulse when a partial frame is discarded on timeout.
REQ-013 overrun  output  1  sticky: a byte arrived and was dropped while header_valid=1.

Function
REQ-014 States IDLE, RECEIVE, HOLD; the state register SHALL have exactly these three encodings.
REQ-015 Byte accept: the block SHALL accept a byte in a cycle where rx_ready=1 and rdy_clr=0, and SHALL drive rdy_clr=1 in the following cycle only.
REQ-016 A single rx_ready assertion SHALL yield exactly one accept, including when rx_ready stays high one cycle after rdy_clr.
REQ-017 On accept in IDLE or RECEIVE: header <= {header[631:0], rx_byte}; byte_count increments; state RECEIVE.
REQ-018 On the accept that is byte number HEADER_BYTES: state HOLD, header_valid=1 in the next cycle, byte_count returns to 0.
REQ-019 Accept-to-header_valid latency SHALL be 1 cycle for the final byte.
REQ-020 In HOLD, header and header_valid SHALL remain stable until header_ack=1 is sampled.
REQ-021 On header_ack=1 in HOLD: state IDLE next cycle, header_valid=0, overrun cleared.
REQ-022 header_ack outside HOLD SHALL be ignored.
REQ-023 Bytes in HOLD SHALL still be drained (rdy_clr pulsed), SHALL NOT modify header or byte_count, and SHALL set overrun.
REQ-024 Byte drop and header_ack in the same cycle: the byte is dropped and overrun SHALL end the cycle set (set wins over clear).
REQ-025 Timeout counter SHALL count cycles in RECEIVE without an accept, clear on every accept, and hold at 0 in IDLE and HOLD.
REQ-026 When the counter reaches TIMEOUT_CYCLES-1 without an accept: state IDLE, byte_count=0, frame_error=1 for one cycle; header content is don't-care.
REQ-027 An accept in the same cycle as timeout expiry SHALL win: the byte is taken and the counter is cleared.
REQ-028 byte_count SHALL never reach HEADER_BYTES.

Reset
REQ-029 While reset=0: state IDLE, header=0, header_valid=0, rdy_clr=0, byte_count=0, frame_error=0, overrun=0, timeout counter=0.
REQ-030 Reset asserted mid-frame or in HOLD SHALL discard all progress; the first accept after release starts a new frame at byte 0.

Verification
REQ-031 Send bytes 0x00..0x4F with 20-cycle gaps -> header_valid=1 one cycle after the 80th accept; header[639:632]=0x00, header[7:0]=0x4F; 80 rdy_clr pulses total.
REQ-032 Hold rx_ready=1 for 3 cycles per byte -> exactly one accept per byte; byte_count increments by 1 per assertion.
REQ-033 Send 10 bytes, then idle TIMEOUT_CYCLES cycles -> frame_error one-cycle pulse, byte_count=0; next 80 bytes form a correct frame.
REQ-034 In HOLD, send 2 bytes without ack -> header unchanged, overrun=1, 2 rdy_clr pulses; byte plus header_ack in same cycle -> overrun=1 after, state IDLE.
REQ-035 Assert reset after 40 bytes -> all outputs at reset values; 80 fresh bytes -> header equals the fresh bytes only.
